pll_phase_stepper: RTL
======================

PLL_PHASE_STEPPER -- requirements
Module: pll_phase_stepper

Interface
REQ-001 SHALL have parameter STEP_W, default 8, width of the step-count request and progress count.
REQ-002 SHALL have parameter TIMEOUT, default 64, maximum number of cycles to wait for psdone after each psstep.
REQ-003 SHALL have parameter SETTLE, default 4, number of idle cycles between psdone and the next psstep.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; psclk of the PLL is driven from the same clock.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port extlock, input, 1 bit: PLL lock indicator, synchronous to clk.
REQ-007 SHALL have port req, input, 1 bit: start request, sampled only in IDLE.
REQ-008 SHALL have port req_sel, input, 3 bits: PLL output channel to shift (0..4).
REQ-009 SHALL have port req_down, input, 1 bit: direction, 1 = phase down.
REQ-010 SHALL have port req_steps, input, STEP_W bits: number of phase steps.
REQ-011 SHALL have port ack, output, 1 bit: one-cycle pulse when a request is accepted.
REQ-012 SHALL have port busy, output, 1 bit: high from acceptance until return to IDLE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse on successful completion.
REQ-014 SHALL have port err, output, 1 bit: one-cycle pulse on rejection or abort.
REQ-015 SHALL have port steps_done, output, STEP_W bits: steps completed in the current or last operation.
REQ-016 SHALL have port psclksel, output, 3 bits: PLL phase-shift channel select.
REQ-017 SHALL have port psdown, output, 1 bit: PLL phase-shift direction.
REQ-018 SHALL have port psstep, output, 1 bit: PLL phase-shift step strobe.
REQ-019 SHALL have port psdone, input, 1 bit: PLL step-complete indication, synchronous to clk.

Function
REQ-020 SHALL implement the FSM states IDLE, STEP, WAIT, SETTLE and FIN.
REQ-021 IDLE, with req=1, extlock=1, req_sel<=4 and req_steps!=0: SHALL latch sel, dir and steps, pulse ack, clear steps_done, and go to STEP on the next cycle.
REQ-022 IDLE, with req=1, extlock=1 and req_steps=0: SHALL pulse ack, then pulse done on the following cycle with no psstep, and busy SHALL stay high for those 2 cycles.
REQ-023 IDLE, with req=1 and either extlock=0 or req_sel>4: SHALL pulse err, SHALL NOT assert ack, and SHALL stay in IDLE.
REQ-024 STEP: SHALL drive psstep=1 for exactly one cycle, then go to WAIT with the timeout counter cleared.
REQ-025 WAIT: on psdone=1 SHALL increment steps_done; it SHALL go to FIN if steps_done+1 equals the latched steps, else to SETTLE.
REQ-026 WAIT: if psdone has not been seen after TIMEOUT cycles, SHALL pulse err and go to IDLE.
REQ-027 SETTLE: SHALL count SETTLE cycles and SHALL require psdone=0 on the last one before going to STEP; if psdone is still 1, it SHALL keep waiting, bounded by TIMEOUT, then err.
REQ-028 FIN: SHALL pulse done for one cycle and go to IDLE.
REQ-029 SHALL drive psclksel and psdown from latched values, held stable from the ack cycle until IDLE is re-entered; in IDLE they SHALL hold their last values.
REQ-030 In any state other than IDLE, extlock=0 SHALL pulse err, force psstep=0 and return to IDLE on the next edge; steps_done SHALL keep the count reached.
REQ-031 In STEP, WAIT, SETTLE and FIN, req SHALL be ignored.
REQ-032 done and err SHALL never assert in the same cycle; err SHALL take priority if a timeout or lock loss coincides with completion.
REQ-033 steps_done SHALL NOT wrap; the maximum request of 2^STEP_W-1 steps SHALL complete normally.
REQ-034 psstep SHALL be registered (no combinational path from inputs).

Reset
REQ-035 rst_n=0 SHALL asynchronously force IDLE with ack=0, busy=0, done=0, err=0, steps_done=0, psclksel=0, psdown=0, psstep=0 and all counters 0.
REQ-036 Reset asserted mid-operation SHALL abort immediately with no err pulse; after release, the block SHALL be in IDLE.

Verification
REQ-037 extlock=1, req with sel=2, down=0, steps=3, and psdone pulsing 2 cycles after each psstep -> exactly 3 psstep pulses, psclksel=2 and psdown=0 stable throughout, steps_done=3, one done pulse, busy falls with done.
REQ-038 extlock=0, req -> err pulse, no ack, busy=0, psstep never asserted; then req_steps=0 with lock -> ack, then done on the next cycle, no psstep.
REQ-039 psdone never asserted -> err exactly TIMEOUT(64) cycles after the WAIT entry, FSM back in IDLE, steps_done=0.
REQ-040 steps=5 with extlock dropped after the 2nd psdone -> err next cycle, steps_done=2, no further psstep.
REQ-041 rst_n pulsed low during WAIT of a steps=4 operation -> all outputs 0 immediately, no err; a subsequent req with steps=1 completes normally.
REQ-042 req_sel=5 -> err pulse, no ack; req held high during busy with different sel/dir -> ignored, latched psclksel/psdown unchanged.

Source files
------------

// File: rtl/pll_phase_stepper_if.sv
// Request/status and PLL dynamic-phase-shift signals of pll_phase_stepper.
// slave: the stepper itself. master: the requester together with the PLL model.
interface pll_phase_stepper_if #(
    parameter int STEP_W = 8
);
    logic              extlock;
    logic              req;
    logic [2:0]        req_sel;
    logic              req_down;
    logic [STEP_W-1:0] req_steps;
    logic              ack;
    logic              busy;
    logic              done;
    logic              err;
    logic [STEP_W-1:0] steps_done;
    logic [2:0]        psclksel;
    logic              psdown;
    logic              psstep;
    logic              psdone;

    modport slave (
        input  extlock, req, req_sel, req_down, req_steps, psdone,
        output ack, busy, done, err, steps_done, psclksel, psdown, psstep
    );

    modport master (
        output extlock, req, req_sel, req_down, req_steps, psdone,
        input  ack, busy, done, err, steps_done, psclksel, psdown, psstep
    );
endinterface

// File: rtl/pll_phase_stepper.sv
// PLL dynamic phase-shift sequencer. On an accepted request it issues a number
// of single-cycle psstep strobes to one PLL output channel, waits for psdone
// after each one (bounded), lets the PLL settle for SETTLE cycles between
// steps, and reports done, or err on timeout / lock loss. All outputs are
// registered; psclksel/psdown come from values latched at acceptance.
module pll_phase_stepper #(
    parameter int STEP_W  = 8,
    parameter int TIMEOUT = 64,
    parameter int SETTLE  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    pll_phase_stepper_if.slave        bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STEP   = 3'd1,
        S_WAIT   = 3'd2,
        S_SETTLE = 3'd3,
        S_FIN    = 3'd4
    } state_t;

    // Counter must reach TIMEOUT-1; it is shared by WAIT and SETTLE.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] C_TO_LAST     = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [2:0]       C_SEL_MAX     = 3'd4;

    state_t              r_state;
    state_t              w_next_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_next_cnt;
    logic [STEP_W-1:0]   r_steps;
    logic [2:0]          r_sel;
    logic                r_down;
    logic [STEP_W-1:0]   r_steps_done;
    logic [STEP_W-1:0]   w_sd_inc;
    logic                r_ack;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic                r_psstep;

    logic                w_req_valid;
    logic                w_accept;
    logic                w_reject;
    logic                w_step_done;
    logic                w_abort;
    logic                w_timeout;
    logic                w_ack_d;
    logic                w_busy_d;
    logic                w_done_d;
    logic                w_err_d;
    logic                w_psstep_d;

    // A request can only be honoured with the PLL locked and a real channel.
    assign w_req_valid = bus.extlock && (bus.req_sel <= C_SEL_MAX);
    assign w_accept    = (r_state == S_IDLE) && bus.req && w_req_valid;
    assign w_reject    = (r_state == S_IDLE) && bus.req && !w_req_valid;
    // steps_done never exceeds the latched count, so this cannot wrap.
    assign w_sd_inc    = r_steps_done + STEP_W'(1);

    // State and step-timing counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Next-state and counter logic; lock loss outranks every other event.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_step_done  = 1'b0;
        w_abort      = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = (bus.req_steps == '0) ? S_FIN : S_STEP;
                    w_next_cnt   = '0;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_STEP: begin
                if (!bus.extlock) begin
                    w_next_state = S_IDLE;
                    w_abort      = 1'b1;
                end else begin
                    w_next_state = S_WAIT;
                    w_next_cnt   = '0;
                end
            end
            S_WAIT: begin
                if (!bus.extlock) begin
                    w_next_state = S_IDLE;
                    w_abort      = 1'b1;
                end else if (bus.psdone) begin
                    w_step_done  = 1'b1;
                    w_next_cnt   = '0;
                    w_next_state = (w_sd_inc == r_steps) ? S_FIN : S_SETTLE;
                end else if (r_cnt == C_TO_LAST) begin
                    w_next_state = S_IDLE;
                    w_timeout    = 1'b1;
                end else begin
                    w_next_cnt   = r_cnt + CNT_W'(1);
                end
            end
            S_SETTLE: begin
                if (!bus.extlock) begin
                    w_next_state = S_IDLE;
                    w_abort      = 1'b1;
                end else if ((r_cnt >= C_SETTLE_LAST) && !bus.psdone) begin
                    w_next_state = S_STEP;
                    w_next_cnt   = '0;
                end else if (r_cnt == C_TO_LAST) begin
                    // psdone stuck high: give up rather than step blindly.
                    w_next_state = S_IDLE;
                    w_timeout    = 1'b1;
                end else begin
                    w_next_cnt   = r_cnt + CNT_W'(1);
                end
            end
            S_FIN: begin
                if (!bus.extlock) begin
                    w_abort = 1'b1;
                end else begin
                    w_abort = 1'b0;
                end
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    // Next values of the registered outputs; err always wins over done.
    always_comb begin
        w_ack_d    = w_accept;
        w_err_d    = w_reject || w_abort || w_timeout;
        w_busy_d   = w_accept || (r_state != S_IDLE);
        w_psstep_d = (w_next_state == S_STEP);
        if ((r_state == S_FIN) && bus.extlock) begin
            w_done_d = 1'b1;
        end else begin
            w_done_d = 1'b0;
        end
    end

    // Output pulse/level registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_psstep <= 1'b0;
        end else begin
            r_ack    <= w_ack_d;
            r_busy   <= w_busy_d;
            r_done   <= w_done_d;
            r_err    <= w_err_d;
            r_psstep <= w_psstep_d;
        end
    end

    // Request latch and progress count; latched values persist through IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_steps      <= '0;
            r_sel        <= 3'd0;
            r_down       <= 1'b0;
            r_steps_done <= '0;
        end else if (w_accept) begin
            r_steps      <= bus.req_steps;
            r_sel        <= bus.req_sel;
            r_down       <= bus.req_down;
            r_steps_done <= '0;
        end else if (w_step_done) begin
            r_steps_done <= w_sd_inc;
        end else begin
            r_steps_done <= r_steps_done;
        end
    end

    assign bus.ack        = r_ack;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
    assign bus.psstep     = r_psstep;
    assign bus.psclksel   = r_sel;
    assign bus.psdown     = r_down;
    assign bus.steps_done = r_steps_done;

endmodule
